// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-stage program loader.
// The checksum variant is selected with PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        HOLD,
        RUN,
        ERR
    } state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h00000013;
    localparam int          IMAGE_DEPTH = 32;

endpackage

// File: rtl/program_loader_image.sv
// Instruction image register file for the loader: async NOP fill on reset,
// sync clear-all and single-word write; drives the core's initial_instructions.
module loader_image
    import program_loader_pkg::*;
#(
    parameter int DEPTH = IMAGE_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear_all,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [DEPTH-1:0][31:0]   instructions
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) instructions[i] <= NOP_INSTR;
        end else if (clear_all) begin
            for (int i = 0; i < DEPTH; i++) instructions[i] <= NOP_INSTR;
        end else if (we) begin
            instructions[idx] <= wdata;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader for the RV32I core: streams in an image and owns the core reset.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for load_req
// HDR   | waiting for header word (length in bits 5:0)
// DATA  | accepting len image words
// CHK   | accepting checksum trailer (checksum build only)
// HOLD  | image complete, core reset held HOLD_CYCLES more cycles
// RUN   | core running from the new image
// ERR   | last load rejected, core held in reset
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH       = IMAGE_DEPTH,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_req,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    output logic                   in_ready,
    output logic [DEPTH-1:0][31:0] instructions,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [5:0]             words_loaded
);

    localparam int         AW        = $clog2(DEPTH);
    localparam int         HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [6:0] DEPTH_LIM = 7'(DEPTH);

    state_e        state;
    logic [5:0]    len_q;
    logic [HW-1:0] hold_cnt;
    logic          accept;
    logic [5:0]    hdr_len;
    logic          hdr_bad;
    logic          last_word;
    logic          img_clear;
    logic          img_we;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]   csum;
`endif

    assign in_ready  = state inside {HDR, DATA, CHK};
    assign accept    = in_valid && in_ready;
    assign hdr_len   = in_data[5:0];
    assign hdr_bad   = (hdr_len == 6'd0) || ({1'b0, hdr_len} > DEPTH_LIM);
    assign last_word = (words_loaded + 6'd1) == len_q;
    assign img_clear = accept && (state == HDR) && !hdr_bad;
    assign img_we    = accept && (state == DATA);

    loader_image #(.DEPTH(DEPTH)) u_image (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_all    (img_clear),
        .we           (img_we),
        .idx          (words_loaded[AW-1:0]),
        .wdata        (in_data),
        .instructions (instructions)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            len_q        <= '0;
            hold_cnt     <= '0;
            words_loaded <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            case (state)
                IDLE, RUN, ERR: begin
                    if (load_req) begin
                        state     <= HDR;
                        busy      <= 1'b1;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state        <= DATA;
                            len_q        <= hdr_len;
                            words_loaded <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            csum         <= in_data;
`endif
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        words_loaded <= words_loaded + 6'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum         <= csum ^ in_data;
                        if (last_word) state <= CHK;
`else
                        if (last_word) begin
                            state    <= HOLD;
                            hold_cnt <= HW'(HOLD_CYCLES);
                        end
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state    <= HOLD;
                            hold_cnt <= HW'(HOLD_CYCLES);
                        end else begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                // terminal count at 1 so cpu_reset drops on the HOLD_CYCLES-th edge
                HOLD: begin
                    if (hold_cnt == HW'(1)) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of load vectors plus
// hand-written sequences for reload, ignored load_req, stall and async reset.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int DEPTH = 32;
    localparam int HOLD  = 2;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   load_req = 1'b0;
    logic                   in_valid = 1'b0;
    logic [31:0]            in_data = '0;
    logic                   in_ready;
    logic [DEPTH-1:0][31:0] instructions;
    logic                   cpu_reset;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [5:0]             words_loaded;

    program_loader #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_req     (load_req),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .instructions (instructions),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hdr;
        bit          gap;
        bit          exp_err;
        int          exp_wl;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_img [DEPTH];
    vec_t        vecs [8];

    function automatic vec_t mk(input string n, input logic [31:0] h, input bit g,
                                input bit e, input int wl);
        vec_t v;
        v.name = n; v.hdr = h; v.gap = g; v.exp_err = e; v.exp_wl = wl;
        return v;
    endfunction

    function automatic logic [31:0] data_word(input int v, input int i);
        if (v < 2) begin
            case (i)
                0:       return 32'h00500093;
                1:       return 32'h00108113;
                default: return 32'h002081B3;
            endcase
        end
        return (32'(v) << 24) ^ 32'h005A_0000 ^ 32'(i * 7 + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_image(input string name);
        int bad = 0;
        int first = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (instructions[i] !== exp_img[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s image: %0d entries differ, entry %0d got %h expected %h",
                     name, bad, first, instructions[first], exp_img[first]);
        end
    endtask

    task automatic model_nop();
        for (int i = 0; i < DEPTH; i++) exp_img[i] = NOP_INSTR;
    endtask

    task automatic send_word(input logic [31:0] d, input bit gap);
        bit ok = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = ~d;
            tick();
        end
        for (int c = 0; c < 20 && !ok; c++) begin
            if (in_ready === 1'b1) begin
                in_valid = 1'b1;
                in_data  = d;
                tick();
                in_valid = 1'b0;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake: in_ready stayed low for 20 cycles");
        end
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_release(input string name);
        int n = 0;
        while (cpu_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({name, " release cycles"}, 32'(n), 32'(HOLD));
    endtask

    // Full load of len data words with bench-computed checksum trailer.
    task automatic load_ok(input string name, input int v, input logic [31:0] hdr,
                           input int len, input bit gap);
        logic [31:0] xr = hdr;
        logic [31:0] d;
        send_word(hdr, gap);
        model_nop();
        for (int i = 0; i < len; i++) begin
            d = data_word(v, i);
            send_word(d, gap);
            exp_img[i] = d;
            xr ^= d;
            chk({name, " words_loaded step"}, 32'(words_loaded), 32'(i + 1));
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_word(xr, gap);
`endif
        chk({name, " hold cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({name, " hold in_ready"}, 32'(in_ready), 32'd0);
        wait_release(name);
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " error"}, 32'(error), 32'd0);
    endtask

    initial begin
        vecs[0] = mk("spec3",     32'h0000_0003, 1'b0, 1'b0, 3);
        vecs[1] = mk("spec3_gap", 32'h0000_0003, 1'b1, 1'b0, 3);
        vecs[2] = mk("len0",      32'h0000_0000, 1'b0, 1'b1, 0);
        vecs[3] = mk("len33",     32'h0000_0021, 1'b0, 1'b1, 0);
        vecs[4] = mk("len1_hi",   32'hFFFF_FFC1, 1'b0, 1'b0, 1);
        vecs[5] = mk("len2_gap",  32'h0000_0042, 1'b1, 1'b0, 2);
        vecs[6] = mk("len63",     32'h0000_003F, 1'b0, 1'b1, 0);
        vecs[7] = mk("len32",     32'h0000_0020, 1'b0, 1'b0, 32);

        model_nop();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("reset cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset error", 32'(error), 32'd0);
        chk("reset words_loaded", 32'(words_loaded), 32'd0);
        chk_image("reset");

        for (int v = 0; v < 8; v++) begin
            pulse_load();
            chk({vecs[v].name, " busy after load_req"}, 32'(busy), 32'd1);
            if (vecs[v].exp_err) begin
                send_word(vecs[v].hdr, vecs[v].gap);
                chk({vecs[v].name, " error"}, 32'(error), 32'd1);
                chk({vecs[v].name, " cpu_reset"}, 32'(cpu_reset), 32'd1);
                chk({vecs[v].name, " busy"}, 32'(busy), 32'd0);
                chk({vecs[v].name, " done"}, 32'(done), 32'd0);
            end else begin
                load_ok(vecs[v].name, v, vecs[v].hdr, vecs[v].exp_wl, vecs[v].gap);
                chk({vecs[v].name, " words_loaded"}, 32'(words_loaded), 32'(vecs[v].exp_wl));
            end
            chk_image(vecs[v].name);
        end

        // Reload from RUN over a full image; a load_req mid-DATA is ignored.
        pulse_load();
        chk("reload cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload done", 32'(done), 32'd0);
        send_word(32'h0000_0002, 1'b0);
        model_nop();
        send_word(32'hCAFE_0001, 1'b0);
        exp_img[0] = 32'hCAFE_0001;
        pulse_load();
        chk("ignored load_req busy", 32'(busy), 32'd1);
        chk("ignored load_req words_loaded", 32'(words_loaded), 32'd1);
        send_word(32'hCAFE_0002, 1'b0);
        exp_img[1] = 32'hCAFE_0002;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_word(32'h0000_0002 ^ 32'hCAFE_0001 ^ 32'hCAFE_0002, 1'b0);
`endif
        wait_release("reload");
        chk("reload done after", 32'(done), 32'd1);
        chk("reload words_loaded", 32'(words_loaded), 32'd2);
        chk_image("reload");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        pulse_load();
        send_word(32'h0000_0001, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0000_0012, 1'b0);
        model_nop();
        exp_img[0] = 32'h0000_0013;
        wait_release("csum good");
        chk("csum good done", 32'(done), 32'd1);
        chk_image("csum good");
        pulse_load();
        send_word(32'h0000_0001, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        chk("csum bad error", 32'(error), 32'd1);
        chk("csum bad cpu_reset", 32'(cpu_reset), 32'd1);
        chk("csum bad done", 32'(done), 32'd0);
        chk_image("csum bad");
`endif

        // Stall in HDR, then async reset in the middle of DATA.
        pulse_load();
        repeat (5) tick();
        chk("stall in_ready", 32'(in_ready), 32'd1);
        chk("stall busy", 32'(busy), 32'd1);
        send_word(32'h0000_0004, 1'b0);
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b0);
        chk("mid words_loaded", 32'(words_loaded), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        model_nop();
        chk("async cpu_reset", 32'(cpu_reset), 32'd1);
        chk("async busy", 32'(busy), 32'd0);
        chk("async in_ready", 32'(in_ready), 32'd0);
        chk("async words_loaded", 32'(words_loaded), 32'd0);
        chk("async done", 32'(done), 32'd0);
        chk("async error", 32'(error), 32'd0);
        chk_image("async reset");
        reset_n = 1'b1;
        repeat (2) tick();
        chk("post reset in_ready", 32'(in_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
